// File: rtl/irig_b_frame_sequencer_if.sv
// Time-field handshake between the time source and the IRIG-B frame sequencer.
interface irig_b_frame_sequencer_if;
  logic       time_valid;
  logic       time_ack;
  logic [6:0] second;
  logic [6:0] minute;
  logic [5:0] hour;
  logic [9:0] day;
  logic [7:0] year;

  modport master (output time_valid, second, minute, hour, day, year, input time_ack);
  modport slave  (input time_valid, second, minute, hour, day, year, output time_ack);
endinterface

// File: rtl/irig_b_frame_sequencer.sv
// IRIG-B transmit sequencer: latches BCD time at frame start, then walks the
// 100 slots of a frame driving the pulse-width-coded irig_b line.
module irig_b_frame_sequencer #(
  parameter int unsigned SYM_CYCLES = 1250000,
  parameter int unsigned P_HIGH     = 1000000,
  parameter int unsigned ONE_HIGH   = 625000,
  parameter int unsigned ZERO_HIGH  = 250000,
  parameter bit          ALIGN_PPS  = 1'b1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       enable,
  input  logic                       pps,
  irig_b_frame_sequencer_if.slave    tbus,
  output logic                       irig_b,
  output logic [6:0]                 sym_index,
  output logic [1:0]                 sym_type,
  output logic                       frame_start,
  output logic                       busy,
  output logic                       resync,
  output logic                       stale
);

  localparam int unsigned    CW       = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SYM_CYCLES - 1);
  localparam logic [1:0]     SYM_ZERO = 2'b00;
  localparam logic [1:0]     SYM_ONE  = 2'b01;
  localparam logic [1:0]     SYM_MARK = 2'b10;

  function automatic logic [99:0] marker_map();
    logic [99:0] m;
    m    = '0;
    m[0] = 1'b1;
    for (int unsigned i = 9; i < 100; i += 10) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [99:0] MARKERS = marker_map();

  typedef enum logic [1:0] {IDLE, ARM, RUN, LAST} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    idx_n;
  logic [1:0]    type_n;
  logic          irig_n, start, resync_n, ack_q;
  logic [31:0]   high_n;
  logic [99:0]   data_bits;

  logic [6:0]    sh_second, sh_minute;
  logic [5:0]    sh_hour;
  logic [9:0]    sh_day;
  logic [7:0]    sh_year;

  assign busy          = (state == RUN);
  assign tbus.time_ack = ack_q;

  always_comb begin
    data_bits        = '0;
    data_bits[4:1]   = sh_second[3:0];
    data_bits[8:6]   = sh_second[6:4];
    data_bits[13:10] = sh_minute[3:0];
    data_bits[17:15] = sh_minute[6:4];
    data_bits[23:20] = sh_hour[3:0];
    data_bits[26:25] = sh_hour[5:4];
    data_bits[33:30] = sh_day[3:0];
    data_bits[38:35] = sh_day[7:4];
    data_bits[41:40] = sh_day[9:8];
    data_bits[53:50] = sh_year[3:0];
    data_bits[58:55] = sh_year[7:4];
  end

  // A frame start (from ARM, a mid-frame pps, or a pps during LAST) overrides
  // whatever the per-state stepping decided.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = sym_index;
    start    = 1'b0;
    resync_n = 1'b0;
    case (state)
      IDLE: if (enable) state_n = ARM;
      ARM: begin
        if (!enable) state_n = IDLE;
        else if (!ALIGN_PPS || pps) start = 1'b1;
      end
      RUN: begin
        if (ALIGN_PPS && pps) begin
          start    = 1'b1;
          resync_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (sym_index == 7'd99) state_n = LAST;
          else idx_n = sym_index + 7'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LAST: begin
        idx_n = '0;
        if (!enable) state_n = IDLE;
        else if (ALIGN_PPS && pps) start = 1'b1;
        else state_n = ARM;
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n = RUN;
      cnt_n   = '0;
      idx_n   = '0;
    end

    type_n = SYM_ZERO;
    if (state_n == RUN) begin
      if (MARKERS[idx_n]) type_n = SYM_MARK;
      else if (data_bits[idx_n]) type_n = SYM_ONE;
    end

    case (type_n)
      SYM_MARK: high_n = P_HIGH;
      SYM_ONE:  high_n = ONE_HIGH;
      default:  high_n = ZERO_HIGH;
    endcase
    irig_n = (state_n == RUN) && (32'(cnt_n) < high_n);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sym_index   <= '0;
      sym_type    <= '0;
      irig_b      <= 1'b0;
      frame_start <= 1'b0;
      resync      <= 1'b0;
      ack_q       <= 1'b0;
      stale       <= 1'b0;
      sh_second   <= '0;
      sh_minute   <= '0;
      sh_hour     <= '0;
      sh_day      <= '0;
      sh_year     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sym_index   <= idx_n;
      sym_type    <= type_n;
      irig_b      <= irig_n;
      frame_start <= start;
      resync      <= resync_n;
      ack_q       <= start && tbus.time_valid;
      if (start) begin
        stale <= !tbus.time_valid;
        if (tbus.time_valid) begin
          sh_second <= tbus.second;
          sh_minute <= tbus.minute;
          sh_hour   <= tbus.hour;
          sh_day    <= tbus.day;
          sh_year   <= tbus.year;
        end
      end
    end
  end

endmodule
